// File: rtl/jtag_dpi_master.sv
// Command-driven JTAG master: turns TAP-reset / shift-IR / shift-DR / idle commands
// into TCK/TMS/TDI waveforms on sys_clk and returns the TDO bits captured while shifting.
module jtag_dpi_master #(
    parameter int CLK_DIV = 2,
    parameter int MAX_LEN = 32
) (
    input  logic                       sys_clk,
    input  logic                       sys_rst_n,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [1:0]                 cmd_op,
    input  logic [$clog2(MAX_LEN)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]         cmd_data,
    output logic                       rsp_valid,
    output logic [MAX_LEN-1:0]         rsp_data,
    output logic                       tck,
    output logic                       tms,
    output logic                       tdi,
    input  logic                       tdo
);
    localparam int LEN_W = $clog2(MAX_LEN);
    localparam int K_W   = $clog2(MAX_LEN + 8);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        OP_RESET = 2'b00,
        OP_IR    = 2'b01,
        OP_DR    = 2'b10,
        OP_IDLE  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    op_t                op_q;
    logic [LEN_W-1:0]   len_q;
    logic [MAX_LEN-1:0] data_q, cap_q;
    logic [K_W-1:0]     k_q, k_nxt, last_k;
    logic [DIV_W-1:0]   div_q;
    logic               auto_q;
    logic               tick, rise, fall, last, accept;
    logic               cur_shift, nxt_shift;
    logic [LEN_W-1:0]   cur_bit, nxt_bit;

    // Index of the first shift TCK: after Select-DR/Capture-DR (or the two extra IR steps).
    function automatic logic [K_W-1:0] shift_start(input op_t op);
        return (op == OP_IR) ? K_W'(4) : K_W'(3);
    endfunction

    function automatic logic is_shift(input op_t op, input logic [LEN_W-1:0] len,
                                      input logic [K_W-1:0] k);
        return (op == OP_DR || op == OP_IR) &&
               (k >= shift_start(op)) && (k <= shift_start(op) + K_W'(len));
    endfunction

    // TMS level for TCK number k of a command; every sequence starts and ends in Run-Test/Idle.
    function automatic logic tms_at(input op_t op, input logic [LEN_W-1:0] len,
                                    input logic [K_W-1:0] k);
        logic [K_W-1:0] last_shift;
        last_shift = shift_start(op) + K_W'(len);
        case (op)
            OP_RESET: return k < K_W'(5);
            OP_IDLE:  return 1'b0;
            OP_IR:    return (k < K_W'(2)) || (k == last_shift) || (k == last_shift + K_W'(1));
            default:  return (k == '0) || (k == last_shift) || (k == last_shift + K_W'(1));
        endcase
    endfunction

    always_comb begin
        case (op_q)
            OP_RESET: last_k = K_W'(5);
            OP_IDLE:  last_k = K_W'(len_q);
            OP_DR:    last_k = K_W'(len_q) + K_W'(5);
            default:  last_k = K_W'(len_q) + K_W'(6);
        endcase
    end

    assign tick      = (div_q == DIV_W'(CLK_DIV - 1));
    assign rise      = (state_q == S_RUN) && tick && !tck;
    assign fall      = (state_q == S_RUN) && tick && tck;
    assign last      = (k_q == last_k);
    assign k_nxt     = k_q + K_W'(1);
    assign cur_shift = is_shift(op_q, len_q, k_q);
    assign nxt_shift = is_shift(op_q, len_q, k_nxt);
    assign cur_bit   = LEN_W'(k_q - shift_start(op_q));
    assign nxt_bit   = LEN_W'(k_nxt - shift_start(op_q));
    assign accept    = cmd_valid && cmd_ready;

    // Reset lands in S_RUN so the automatic TAP reset starts as soon as reset releases.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state_q <= S_RUN;
        else            state_q <= state_d;
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d   = state_q;
        cmd_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_d = S_RUN;
            end
            S_RUN:   if (fall && last) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!sys_rst_n) begin
            op_q      <= OP_RESET;
            len_q     <= '0;
            data_q    <= '0;
            cap_q     <= '0;
            k_q       <= '0;
            div_q     <= '0;
            auto_q    <= 1'b1;
            tck       <= 1'b0;
            tms       <= 1'b1;
            tdi       <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                op_q   <= op_t'(cmd_op);
                len_q  <= cmd_len;
                data_q <= cmd_data;
                cap_q  <= '0;
                k_q    <= '0;
                div_q  <= '0;
                auto_q <= 1'b0;
                tms    <= tms_at(op_t'(cmd_op), cmd_len, '0);
                tdi    <= 1'b0;
            end else if (state_q == S_RUN) begin
                if (tick) begin
                    div_q <= '0;
                    tck   <= ~tck;
                    if (rise) begin
                        if (cur_shift) cap_q[cur_bit] <= tdo;
                    end else if (!last) begin
                        k_q <= k_nxt;
                        tms <= tms_at(op_q, len_q, k_nxt);
                        tdi <= nxt_shift ? data_q[nxt_bit] : 1'b0;
                    end else begin
                        tms <= 1'b0;
                        tdi <= 1'b0;
                    end
                end else begin
                    div_q <= div_q + DIV_W'(1);
                end
            end else if (state_q == S_DONE && !auto_q) begin
                rsp_valid <= 1'b1;
                rsp_data  <= cap_q;
            end
        end
    end

endmodule

// File: tb/tb_jtag_dpi_master.sv
// Bench for jtag_dpi_master: directed table, randomized commands against a queue-based
// model of the TMS/TDI/TDO rules, plus reset and mid-operation reset sequences.
module tb_jtag_dpi_master;
    localparam int MAX_LEN = 32;
    localparam int MON_N   = 4096;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [1:0]  cmd_valid;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_len;
    logic [31:0] cmd_data;
    logic [1:0]  cmd_ready, rsp_valid, tck, tms, tdi, tdo;
    logic [31:0] rsp_data [2];

    bit          loop_mode = 1'b0;
    logic [63:0] tdo_pat = '0;
    int          tdo_base = 0;
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;

    int          mon_cnt [2] = '{0, 0};
    int          rsp_cnt [2] = '{0, 0};
    bit          mon_tms [2][MON_N];
    bit          mon_tdi [2][MON_N];
    int          mon_cyc [2][MON_N];
    logic [1:0]  tck_prev = 2'b00;

    typedef struct {
        int          u;
        logic [1:0]  op;
        logic [4:0]  len;
        logic [31:0] data;
        bit          loop;
        logic [63:0] pat;
        bit          jam;
        logic [31:0] exp_rsp;
        int          exp_lat;
    } vec_t;

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    jtag_dpi_master #(.CLK_DIV(2), .MAX_LEN(MAX_LEN)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid[0]), .rsp_data(rsp_data[0]),
        .tck(tck[0]), .tms(tms[0]), .tdi(tdi[0]), .tdo(tdo[0])
    );

    jtag_dpi_master #(.CLK_DIV(1), .MAX_LEN(MAX_LEN)) u_dut_fast (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]), .cmd_op(cmd_op),
        .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid[1]), .rsp_data(rsp_data[1]),
        .tck(tck[1]), .tms(tms[1]), .tdi(tdi[1]), .tdo(tdo[1])
    );

    // Target model: TDO is either TDI looped back or a pattern bit chosen by TCK index.
    assign tdo[0] = loop_mode ? tdi[0] : tdo_pat[6'(mon_cnt[0] - tdo_base)];
    assign tdo[1] = loop_mode ? tdi[1] : tdo_pat[6'(mon_cnt[1] - tdo_base)];

    always @(negedge sys_clk) begin
        for (int u = 0; u < 2; u++) begin
            if (tck[u] === 1'b1 && tck_prev[u] === 1'b0 && mon_cnt[u] < MON_N) begin
                mon_tms[u][mon_cnt[u]] <= tms[u];
                mon_tdi[u][mon_cnt[u]] <= tdi[u];
                mon_cyc[u][mon_cnt[u]] <= cyc;
                mon_cnt[u]             <= mon_cnt[u] + 1;
            end
            if (rsp_valid[u] === 1'b1) rsp_cnt[u] <= rsp_cnt[u] + 1;
        end
        tck_prev <= tck;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // Reference: per-TCK TMS/TDI lists built from the command rules, plus expected capture.
    task automatic model(input logic [1:0] op, input int len, input logic [31:0] data,
                         input bit loop, input logic [63:0] pat, output int n_tck,
                         output logic [63:0] tms_e, output logic [63:0] tdi_e,
                         output logic [31:0] rsp_e);
        bit tq[$];
        bit dq[$];
        int hdr;
        int n;
        n     = len + 1;
        rsp_e = '0;
        tms_e = '0;
        tdi_e = '0;
        case (op)
            2'b00: tq = '{1, 1, 1, 1, 1, 0};
            2'b11: for (int i = 0; i < n; i++) tq.push_back(1'b0);
            default: begin
                if (op == 2'b10) tq = '{1, 0, 0};
                else             tq = '{1, 1, 0, 0};
                hdr = tq.size();
                for (int i = 0; i < hdr; i++) dq.push_back(1'b0);
                for (int i = 0; i < n; i++) begin
                    tq.push_back(i == n - 1);
                    dq.push_back(data[i]);
                    rsp_e[i] = loop ? data[i] : pat[hdr + i];
                end
                tq.push_back(1'b1);
                tq.push_back(1'b0);
            end
        endcase
        while (dq.size() < tq.size()) dq.push_back(1'b0);
        n_tck = tq.size();
        for (int i = 0; i < n_tck; i++) begin
            tms_e[i] = tq[i];
            tdi_e[i] = dq[i];
        end
    endtask

    task automatic run_cmd(input int u, input logic [1:0] op, input logic [4:0] len,
                           input logic [31:0] data, input bit loop, input logic [63:0] pat,
                           input bit jam, output logic [31:0] got, output int lat);
        int cd, base, rsp0, acc, guard, ready_hi, n_e, errs;
        logic [63:0] tms_e, tdi_e, tms_a, tdi_a;
        logic [31:0] rsp_e;
        cd = (u == 0) ? 2 : 1;
        model(op, int'(len), data, loop, pat, n_e, tms_e, tdi_e, rsp_e);
        guard = 0;
        while (cmd_ready[u] !== 1'b1 && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
        end
        check("ready_before_cmd", cmd_ready[u], 1);
        loop_mode = loop;
        tdo_pat   = pat;
        tdo_base  = mon_cnt[u];
        base      = mon_cnt[u];
        rsp0      = rsp_cnt[u];
        cmd_op    = op;
        cmd_len   = len;
        cmd_data  = data;
        cmd_valid[u] = 1'b1;
        acc = cyc + 1;
        @(negedge sys_clk);
        if (jam) begin
            cmd_op   = 2'b11;
            cmd_len  = '0;
            cmd_data = '1;
        end else begin
            cmd_valid[u] = 1'b0;
        end
        guard    = 0;
        ready_hi = 0;
        while (rsp_valid[u] !== 1'b1 && guard < 2000) begin
            if (cmd_ready[u] !== 1'b0) ready_hi++;
            @(negedge sys_clk);
            guard++;
            if (guard == 8) cmd_valid[u] = 1'b0;
        end
        cmd_valid[u] = 1'b0;
        lat = cyc - acc;
        got = rsp_data[u];
        check("latency", lat, 2 * cd * n_e + 1);
        check("rsp_data", got, rsp_e);
        check("ready_low_busy", ready_hi, 0);
        check("tck_low_at_rsp", tck[u], 0);
        check("tck_count", mon_cnt[u] - base, n_e);
        tms_a = '0;
        tdi_a = '0;
        errs  = 0;
        for (int i = 0; i < n_e && base + i < MON_N; i++) begin
            tms_a[i] = mon_tms[u][base + i];
            tdi_a[i] = mon_tdi[u][base + i];
            if (mon_cyc[u][base + i] != acc + cd + 2 * cd * i) errs++;
        end
        check("tms_seq", tms_a, tms_e);
        check("tdi_seq", tdi_a, tdi_e);
        check("tck_timing", errs, 0);
        @(negedge sys_clk);
        check("rsp_one_cycle", rsp_valid[u], 0);
        check("rsp_hold", rsp_data[u], got);
        check("rsp_count", rsp_cnt[u] - rsp0, 1);
    endtask

    task automatic check_auto(input int u, input int base, input int rsp0);
        int cd, guard, errs;
        logic [63:0] tms_a, tdi_a;
        cd    = (u == 0) ? 2 : 1;
        guard = 0;
        while (cmd_ready[u] !== 1'b1 && guard < 200) begin
            @(negedge sys_clk);
            guard++;
        end
        check("auto_ready", cmd_ready[u], 1);
        check("auto_tck_count", mon_cnt[u] - base, 6);
        tms_a = '0;
        tdi_a = '0;
        errs  = 0;
        for (int i = 0; i < 6; i++) begin
            tms_a[i] = mon_tms[u][base + i];
            tdi_a[i] = mon_tdi[u][base + i];
            if (i > 0 && mon_cyc[u][base + i] - mon_cyc[u][base + i - 1] != 2 * cd) errs++;
        end
        check("auto_tms", tms_a, 64'h1F);
        check("auto_tdi", tdi_a, 64'h0);
        check("auto_period", errs, 0);
        repeat (4) @(negedge sys_clk);
        check("auto_no_rsp", rsp_cnt[u] - rsp0, 0);
        check("auto_quiet", mon_cnt[u] - base, 6);
    endtask

    task automatic apply_reset(input int cycles);
        int b0, b1, r0, r1;
        @(negedge sys_clk);
        sys_rst_n = 1'b0;
        cmd_valid = 2'b00;
        repeat (cycles) @(negedge sys_clk);
        check("rst_outputs", {tck, tms, tdi, cmd_ready, rsp_valid}, 10'b00_11_00_00_00);
        check("rst_rsp_data0", rsp_data[0], 0);
        check("rst_rsp_data1", rsp_data[1], 0);
        b0 = mon_cnt[0];
        b1 = mon_cnt[1];
        r0 = rsp_cnt[0];
        r1 = rsp_cnt[1];
        sys_rst_n = 1'b1;
        check_auto(0, b0, r0);
        check_auto(1, b1, r1);
    endtask

    initial begin
        vec_t        vecs [8];
        logic [31:0] got;
        int          lat;
        int          r0;
        int          u;
        int          guard;

        sys_rst_n = 1'b0;
        cmd_valid = 2'b00;
        cmd_op    = 2'b00;
        cmd_len   = '0;
        cmd_data  = '0;

        vecs[0] = '{0, 2'b10, 5'd7,  32'h38,       1'b1, 64'h0,                 1'b0, 32'h38,       53};
        vecs[1] = '{0, 2'b01, 5'd3,  32'hA,        1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 32'hF,      41};
        vecs[2] = '{0, 2'b11, 5'd4,  32'hFFFF_FFFF, 1'b0, 64'h0,                 1'b0, 32'h0,        21};
        vecs[3] = '{0, 2'b00, 5'd9,  32'h5,        1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 32'h0,       25};
        vecs[4] = '{1, 2'b10, 5'd0,  32'h0,        1'b0, 64'h0,                 1'b0, 32'h0,        13};
        vecs[5] = '{0, 2'b01, 5'd31, 32'hDEAD_BEEF, 1'b1, 64'h0,                 1'b0, 32'hDEAD_BEEF, 153};
        vecs[6] = '{0, 2'b10, 5'd31, 32'h0,        1'b0, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0, 32'h1E1E_1E1E, 149};
        vecs[7] = '{1, 2'b01, 5'd5,  32'h2A,       1'b1, 64'h0,                 1'b0, 32'h2A,       25};

        apply_reset(3);

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].u, vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].loop,
                    vecs[i].pat, vecs[i].jam, got, lat);
            check($sformatf("vec%0d_rsp", i), got, vecs[i].exp_rsp);
            check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
        end

        for (int r = 0; r < 16; r++) begin
            u = ($urandom_range(0, 3) == 0) ? 1 : 0;
            run_cmd(u, 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), $urandom,
                    1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'b0, got, lat);
        end

        // Reset while a DR shift is in progress: abort at the next edge, no response.
        guard = 0;
        while (cmd_ready[0] !== 1'b1 && guard < 2000) begin
            @(negedge sys_clk);
            guard++;
        end
        loop_mode = 1'b1;
        r0        = rsp_cnt[0];
        cmd_op    = 2'b10;
        cmd_len   = 5'd15;
        cmd_data  = $urandom;
        cmd_valid[0] = 1'b1;
        @(negedge sys_clk);
        cmd_valid[0] = 1'b0;
        repeat (30) @(negedge sys_clk);
        check("midrst_tck_before", tck[0], 1);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("midrst_tck", tck[0], 0);
        check("midrst_tms", tms[0], 1);
        check("midrst_tdi", tdi[0], 0);
        check("midrst_ready", cmd_ready[0], 0);
        check("midrst_rsp_valid", rsp_valid[0], 0);
        apply_reset(2);
        check("midrst_no_rsp", rsp_cnt[0] - r0, 0);

        run_cmd(0, 2'b10, 5'd7, 32'h38, 1'b1, 64'h0, 1'b0, got, lat);
        check("post_rst_rsp", got, 32'h38);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
